bcd_counter_n: RTL and testbench

Parametrised multi-digit BCD up/down counter with synchronous parallel load, count enable and wrap indication. It generalises the team's single-digit 0–9 counter to `DIGITS` cascaded decades. It sits in the display/timing path, driving 7-segment decoders and stopwatch/timer logic directly in packed BCD.

---
 rtl/bcd_pkg.sv | 30 +++
 rtl/bcd_digit.sv | 40 ++++
 rtl/bcd_counter_n.sv | 115 +++++++++++
 tb/tb_bcd_counter_n.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// bcd_pkg: types, constants and helpers shared by the BCD counter slice.
//   bcd_digit_t  : one packed BCD decade (4 bits, legal values 0-9)
//   BCD_MAX/MIN  : terminal values of a decade
//   bcd_san_t    : sanitised digit plus an error flag
//   bcd_sanitize : maps 10-15 to 0 and flags that the digit was replaced
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  typedef struct packed {
    logic       err;
    bcd_digit_t digit;
  } bcd_san_t;

  function automatic bcd_san_t bcd_sanitize(input bcd_digit_t d);
    bcd_san_t r;
    if (d > BCD_MAX) begin
      r.err   = 1'b1;
      r.digit = BCD_MIN;
    end else begin
      r.err   = 1'b0;
      r.digit = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one decade register of the multi-digit BCD counter.
// Ports:
//   clk, reset (async, active high)
//   load      : take load_val (caller supplies an already sanitised digit)
//   load_val  : digit to load
//   inc, dec  : carry-in / borrow-in from the previous decade (never both)
//   q         : current digit
//   carry     : this decade rolls 9 -> 0 on an increment
//   borrow    : this decade rolls 0 -> 9 on a decrement
// carry/borrow are combinational so the chain ripples within one cycle.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  bcd_digit_t load_val,
  input  logic       inc,
  input  logic       dec,
  output bcd_digit_t q,
  output logic       carry,
  output logic       borrow
);

  assign carry  = inc && (q == BCD_MAX);
  assign borrow = dec && (q == BCD_MIN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= BCD_MIN;
    end else if (load) begin
      q <= load_val;
    end else if (inc) begin
      q <= (q == BCD_MAX) ? BCD_MIN : q + 4'd1;
    end else if (dec) begin
      q <= (q == BCD_MIN) ? BCD_MAX : q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_counter_n.sv
// bcd_counter_n: DIGITS-decade packed BCD up/down counter with synchronous
// parallel load, count enable and a registered wrap pulse.
// Parameters:
//   DIGITS    : number of decades (1-8)
// Ports:
//   clk, reset (async, active high)
//   en        : count one step per cycle while high
//   up_dn     : 1 = count up, 0 = count down
//   load      : synchronous load, overrides en
//   load_val  : packed BCD load value, digit 0 in [3:0]
//   count     : registered packed BCD value
//   wrap      : one-cycle pulse after the count wrapped (or, when saturating,
//               after an enabled step was blocked at the terminal value)
//   load_err  : set when the most recent load held a non-BCD digit
// Build option: define BCD_COUNTER_SATURATE_EN to saturate at all nines /
// all zeros instead of wrapping.
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic                  load_err
);

  logic [DIGITS-1:0][3:0] digits;
  logic [DIGITS-1:0][3:0] san_digits;
  logic [DIGITS:0]        inc_c;
  logic [DIGITS:0]        dec_c;
  logic                   any_err;
  logic                   all_nine;
  logic                   all_zero;
  logic                   step_up;
  logic                   step_dn;
  logic                   blocked;
  logic                   wrap_next;

  assign count = digits;

  // Sanitise every incoming digit and collect the error flags.
  always_comb begin
    bcd_san_t s;
    any_err    = 1'b0;
    san_digits = '0;
    for (int i = 0; i < DIGITS; i++) begin
      s             = bcd_sanitize(load_val[4*i +: 4]);
      san_digits[i] = s.digit;
      any_err       = any_err | s.err;
    end
  end

  // Terminal-value detection on the registered count.
  always_comb begin
    all_nine = 1'b1;
    all_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (digits[i] != BCD_MAX) all_nine = 1'b0;
      if (digits[i] != BCD_MIN) all_zero = 1'b0;
    end
  end

  // Load wins over en, so a load edge never steps the chain.
  assign step_up = en && !load && up_dn;
  assign step_dn = en && !load && !up_dn;

`ifdef BCD_COUNTER_SATURATE_EN
  // A step that would leave the terminal value is swallowed and reported.
  assign blocked  = (step_up && all_nine) || (step_dn && all_zero);
  assign inc_c[0] = step_up && !blocked;
  assign dec_c[0] = step_dn && !blocked;
  // With the chain gated, the top carry/borrow can never fire; it is kept in
  // the expression so the chain end stays connected.
  assign wrap_next = blocked || inc_c[DIGITS] || dec_c[DIGITS];
`else
  assign blocked  = 1'b0;
  assign inc_c[0] = step_up;
  assign dec_c[0] = step_dn;
  // A carry/borrow out of the top decade is exactly a full wrap.
  assign wrap_next = inc_c[DIGITS] || dec_c[DIGITS] || blocked;
`endif

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .load_val (san_digits[g]),
      .inc      (inc_c[g]),
      .dec      (dec_c[g]),
      .q        (digits[g]),
      .carry    (inc_c[g+1]),
      .borrow   (dec_c[g+1])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      wrap     <= 1'b0;
      load_err <= any_err;
    end else begin
      wrap     <= wrap_next;
    end
  end

endmodule

// File: tb/tb_bcd_counter_n.sv
// tb_bcd_counter_n: directed self-checking bench for bcd_counter_n, DIGITS=4.
module tb_bcd_counter_n;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk;
  logic         reset;
  logic         en;
  logic         up_dn;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic         wrap;
  logic         load_err;

  int total;
  int bad;

  // Scoreboard: expected count values queued by the stimulus, popped on check.
  logic [W-1:0] exp_q[$];

  bcd_counter_n #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .wrap     (wrap),
    .load_err (load_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generic comparison.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pop the next expected count and compare, plus wrap/load_err.
  task automatic check_state(input string tag, input logic exp_wrap, input logic exp_err);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_count"}, 32'(count), 32'(e));
    end
    check({tag, "_wrap"}, 32'(wrap), 32'(exp_wrap));
    check({tag, "_err"}, 32'(load_err), 32'(exp_err));
  endtask

  // Drivers: set inputs, advance one edge, sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] v, input logic with_en);
    load     = 1'b1;
    load_val = v;
    en       = with_en;
    step();
    load     = 1'b0;
    en       = 1'b0;
  endtask

  task automatic do_count(input logic dir);
    en    = 1'b1;
    up_dn = dir;
    step();
    en    = 1'b0;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    en       = 1'b0;
    up_dn    = 1'b1;
    load     = 1'b0;
    load_val = '0;

    // Reset state
    #3;
    exp_q.push_back(16'h0000);
    check_state("reset_init", 1'b0, 1'b0);
    #9 reset = 1'b0;

    // Invalid load sets load_err, then count a step, then async reset mid-cycle
    do_load(16'h04A7, 1'b0);
    exp_q.push_back(16'h0407);
    check_state("load_04A7", 1'b0, 1'b1);
    do_count(1'b1);
    exp_q.push_back(16'h0408);
    check_state("up_0408", 1'b0, 1'b1);
    #2 reset = 1'b1;
    #1;
    exp_q.push_back(16'h0000);
    check_state("async_reset", 1'b0, 1'b0);
    step();
    reset = 1'b0;
    step();
    exp_q.push_back(16'h0000);
    check_state("hold_after_reset", 1'b0, 1'b0);

    // Up-count carry across decades
    do_load(16'h0998, 1'b0);
    exp_q.push_back(16'h0998);
    check_state("load_0998", 1'b0, 1'b0);
    do_count(1'b1);
    exp_q.push_back(16'h0999);
    check_state("up_0999", 1'b0, 1'b0);
    do_count(1'b1);
    exp_q.push_back(16'h1000);
    check_state("up_1000", 1'b0, 1'b0);
    do_count(1'b1);
    exp_q.push_back(16'h1001);
    check_state("up_1001", 1'b0, 1'b0);

    // Down-count borrow across decades
    do_load(16'h1000, 1'b0);
    exp_q.push_back(16'h1000);
    check_state("load_1000", 1'b0, 1'b0);
    do_count(1'b0);
    exp_q.push_back(16'h0999);
    check_state("dn_0999", 1'b0, 1'b0);

    // Terminal values
    do_load(16'h9999, 1'b0);
    exp_q.push_back(16'h9999);
    check_state("load_9999", 1'b0, 1'b0);
`ifdef BCD_COUNTER_SATURATE_EN
    for (int i = 0; i < 3; i++) begin
      do_count(1'b1);
      exp_q.push_back(16'h9999);
      check_state("sat_up_9999", 1'b1, 1'b0);
    end
    en = 1'b0;
    step();
    exp_q.push_back(16'h9999);
    check_state("sat_hold", 1'b0, 1'b0);
    do_load(16'h0000, 1'b0);
    exp_q.push_back(16'h0000);
    check_state("load_0000", 1'b0, 1'b0);
    do_count(1'b0);
    exp_q.push_back(16'h0000);
    check_state("sat_dn_0000", 1'b1, 1'b0);
`else
    do_count(1'b1);
    exp_q.push_back(16'h0000);
    check_state("wrap_up", 1'b1, 1'b0);
    do_count(1'b0);
    exp_q.push_back(16'h9999);
    check_state("wrap_dn", 1'b1, 1'b0);
    en = 1'b0;
    step();
    exp_q.push_back(16'h9999);
    check_state("hold_9999", 1'b0, 1'b0);
    do_load(16'h0000, 1'b0);
    exp_q.push_back(16'h0000);
    check_state("load_0000", 1'b0, 1'b0);
    do_count(1'b0);
    exp_q.push_back(16'h9999);
    check_state("wrap_dn_0000", 1'b1, 1'b0);
`endif

    // Invalid load sanitises digits; counting keeps load_err; valid load clears it
    do_load(16'h3A5F, 1'b0);
    exp_q.push_back(16'h3050);
    check_state("load_3A5F", 1'b0, 1'b1);
    do_count(1'b1);
    exp_q.push_back(16'h3051);
    check_state("up_3051", 1'b0, 1'b1);
    do_load(16'h1234, 1'b0);
    exp_q.push_back(16'h1234);
    check_state("load_1234", 1'b0, 1'b0);

    // Load and en together: load wins; then en alone advances
    up_dn = 1'b1;
    do_load(16'h0042, 1'b1);
    exp_q.push_back(16'h0042);
    check_state("load_en_0042", 1'b0, 1'b0);
    do_count(1'b1);
    exp_q.push_back(16'h0043);
    check_state("up_0043", 1'b0, 1'b0);

    // Direction changes cycle by cycle
    do_count(1'b0);
    exp_q.push_back(16'h0042);
    check_state("dn_0042", 1'b0, 1'b0);
    do_count(1'b1);
    exp_q.push_back(16'h0043);
    check_state("up_again_0043", 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
